vga_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_timing.sv | 78 +++++++
 rtl/vga_controller.sv | 75 +++++++
 tb/tb_vga_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 Hz timing constants, derived sync positions and the colour-bar LUT.
package vga_pkg;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned NUM_BARS  = 8;
    localparam int unsigned BAR_IDX_W = 3;

    typedef logic [11:0] rgb_t;

    localparam rgb_t RGB_BLACK = 12'h000;

    // Colour of vertical bar idx, left to right: white, yellow, cyan, green,
    // magenta, red, blue, black.
    function automatic rgb_t bar_color(input logic [BAR_IDX_W-1:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-rate divider, horizontal/vertical counters and the
// combinational sync / visible-area decode of the current counter state.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned ClkDiv   = CLK_DIV,
    parameter int unsigned HVisible = H_VISIBLE,
    parameter int unsigned HFp      = H_FP,
    parameter int unsigned HSync    = H_SYNC,
    parameter int unsigned HBp      = H_BP,
    parameter int unsigned VVisible = V_VISIBLE,
    parameter int unsigned VFp      = V_FP,
    parameter int unsigned VSync    = V_SYNC,
    parameter int unsigned VBp      = V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] h_o,
    output logic             visible_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o
);

    localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    localparam logic [DivW-1:0]  DivMax  = DivW'(ClkDiv - 1);
    localparam logic [CNT_W-1:0] HMax    = CNT_W'(HVisible + HFp + HSync + HBp - 1);
    localparam logic [CNT_W-1:0] VMax    = CNT_W'(VVisible + VFp + VSync + VBp - 1);
    localparam logic [CNT_W-1:0] HVis    = CNT_W'(HVisible);
    localparam logic [CNT_W-1:0] VVis    = CNT_W'(VVisible);
    localparam logic [CNT_W-1:0] HsStart = CNT_W'(HVisible + HFp);
    localparam logic [CNT_W-1:0] HsEnd   = CNT_W'(HVisible + HFp + HSync);
    localparam logic [CNT_W-1:0] VsStart = CNT_W'(VVisible + VFp);
    localparam logic [CNT_W-1:0] VsEnd   = CNT_W'(VVisible + VFp + VSync);

    logic [DivW-1:0]  div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             tick;

    // Next-state: divider wraps every pixel; h advances per pixel, v per line end.
    always_comb begin
        tick  = (div_q == DivMax);
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == HMax) begin
                h_d = '0;
                v_d = (v_q == VMax) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Counter state; reset restarts the raster at pixel (0,0).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Decode of the current raster position; syncs are active low.
    always_comb begin
        h_o       = h_q;
        visible_o = (h_q < HVis) && (v_q < VVis);
        hsync_n_o = !((h_q >= HsStart) && (h_q < HsEnd));
        vsync_n_o = !((v_q >= VsStart) && (v_q < VsEnd));
    end

endmodule

// File: rtl/vga_controller.sv
// vga_controller: VGA timing plus an 8-bar colour test pattern, all outputs
// registered one clock after the counter state they describe.
module vga_controller
    import vga_pkg::*;
#(
    parameter int unsigned ClkDiv   = CLK_DIV,
    parameter int unsigned HVisible = H_VISIBLE,
    parameter int unsigned HFp      = H_FP,
    parameter int unsigned HSync    = H_SYNC,
    parameter int unsigned HBp      = H_BP,
    parameter int unsigned VVisible = V_VISIBLE,
    parameter int unsigned VFp      = V_FP,
    parameter int unsigned VSync    = V_SYNC,
    parameter int unsigned VBp      = V_BP
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_horizontal_sync,
    output logic        io_vertical_sync,
    output logic [11:0] io_rgb_color
);

    localparam logic [CNT_W-1:0] BarW = CNT_W'(HVisible / NUM_BARS);

    logic [CNT_W-1:0]     h;
    logic                 visible;
    logic                 hsync_n;
    logic                 vsync_n;
    logic [BAR_IDX_W-1:0] bar_idx;
    rgb_t                 rgb_d, rgb_q;
    logic                 hsync_q, vsync_q;

    vga_timing #(
        .ClkDiv   (ClkDiv),
        .HVisible (HVisible),
        .HFp      (HFp),
        .HSync    (HSync),
        .HBp      (HBp),
        .VVisible (VVisible),
        .VFp      (VFp),
        .VSync    (VSync),
        .VBp      (VBp)
    ) u_timing (
        .clk_i     (clock),
        .rst_i     (reset),
        .h_o       (h),
        .visible_o (visible),
        .hsync_n_o (hsync_n),
        .vsync_n_o (vsync_n)
    );

    // Pattern: bar colour picked by h inside the visible window, black in blanking.
    always_comb begin
        bar_idx = BAR_IDX_W'(h / BarW);
        rgb_d   = visible ? bar_color(bar_idx) : RGB_BLACK;
    end

    // Output registers; reset parks the connector in idle (syncs high, black).
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= RGB_BLACK;
        end else begin
            hsync_q <= hsync_n;
            vsync_q <= vsync_n;
            rgb_q   <= rgb_d;
        end
    end

    assign io_horizontal_sync = hsync_q;
    assign io_vertical_sync   = vsync_q;
    assign io_rgb_color       = rgb_q;

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: directed checkpoints pushed into a scoreboard queue and
// checked by a monitor every clock, plus sync pulse width / period checks.
// The vertical timing is shortened to a 10-line frame (4 visible, fp 1,
// sync 2, bp 3) so a full frame fits the run; horizontal timing is nominal.
module tb_vga_controller;

    localparam int LINE    = 3200;
    localparam int FRAME   = 10 * LINE;
    localparam int HS_LOW  = 384;
    localparam int VS_LOW  = 2 * LINE;

    logic        clock = 1'b0;
    logic        reset;
    logic        hs, vs;
    logic [11:0] rgb;

    vga_controller #(
        .VVisible (4),
        .VFp      (1),
        .VSync    (2),
        .VBp      (3)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .io_horizontal_sync (hs),
        .io_vertical_sync   (vs),
        .io_rgb_color       (rgb)
    );

    always #5 clock = ~clock;

    // t = number of rising edges seen so far.
    int t = 0;
    always @(posedge clock) t <= t + 1;

    typedef struct {
        int          key;
        int          clk;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   base  = 0;

    task automatic push(input int b, input int k, input logic ehs, input logic evs,
                        input logic [11:0] ergb);
        exp_t e;
        e.key = b + k;
        e.clk = k;
        e.hs  = ehs;
        e.vs  = evs;
        e.rgb = ergb;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int target);
        do begin
            @(posedge clock);
            #2;
        end while (t < target);
    endtask

    // Monitor: at the negedge, outputs equal what edge number t will sample.
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    bit   hs_fall_ok = 0, vs_fall_ok = 0, hs_low = 0, vs_low = 0;
    int   hs_fall = 0, vs_fall = 0, hs_pulses = 0, vs_falls = 0;

    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].key < t) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL cp clk=%0d: not observed, required hs=%b vs=%b rgb=%h",
                     e.clk, e.hs, e.vs, e.rgb);
        end
        if (sb.size() > 0 && sb[0].key == t) begin
            e = sb.pop_front();
            total++;
            if ({hs, vs, rgb} !== {e.hs, e.vs, e.rgb}) begin
                bad++;
                $display("FAIL cp clk=%0d: got hs=%b vs=%b rgb=%h, required hs=%b vs=%b rgb=%h",
                         e.clk, hs, vs, rgb, e.hs, e.vs, e.rgb);
            end
        end
        if (reset) begin
            hs_fall_ok = 0;
            vs_fall_ok = 0;
            hs_low     = 0;
            vs_low     = 0;
        end else begin
            if (hs_prev === 1'b1 && hs === 1'b0) begin
                if (hs_fall_ok) begin
                    total++;
                    if (t - hs_fall != LINE) begin
                        bad++;
                        $display("FAIL hsync period: got %0d required %0d", t - hs_fall, LINE);
                    end
                end
                hs_fall    = t;
                hs_fall_ok = 1;
                hs_low     = 1;
            end
            if (hs_prev === 1'b0 && hs === 1'b1 && hs_low) begin
                total++;
                hs_pulses++;
                hs_low = 0;
                if (t - hs_fall != HS_LOW) begin
                    bad++;
                    $display("FAIL hsync width: got %0d required %0d", t - hs_fall, HS_LOW);
                end
            end
            if (vs_prev === 1'b1 && vs === 1'b0) begin
                vs_falls++;
                if (vs_fall_ok) begin
                    total++;
                    if (t - vs_fall != FRAME) begin
                        bad++;
                        $display("FAIL vsync period: got %0d required %0d", t - vs_fall, FRAME);
                    end
                end
                vs_fall    = t;
                vs_fall_ok = 1;
                vs_low     = 1;
            end
            if (vs_prev === 1'b0 && vs === 1'b1 && vs_low) begin
                total++;
                vs_low = 0;
                if (t - vs_fall != VS_LOW) begin
                    bad++;
                    $display("FAIL vsync width: got %0d required %0d", t - vs_fall, VS_LOW);
                end
            end
        end
        hs_prev = hs;
        vs_prev = vs;
    end

    initial begin
        reset = 1'b1;
        // Reset held for edges 0..2: idle outputs throughout.
        push(0, 1, 1'b1, 1'b1, 12'h000);
        push(0, 2, 1'b1, 1'b1, 12'h000);
        wait_until(3);
        reset = 1'b0;
        base  = t;
        push(base, 0,    1'b1, 1'b1, 12'h000);
        push(base, 1,    1'b1, 1'b1, 12'hFFF);
        push(base, 321,  1'b1, 1'b1, 12'hFF0);
        push(base, 2625, 1'b0, 1'b1, 12'h000);
        push(base, 7600, 1'b1, 1'b1, 12'h0F0);  // h=299, v=2

        // One-clock reset pulse sampled while the counters sit at h=300, v=2.
        wait_until(base + 7600);
        reset = 1'b1;
        wait_until(base + 7601);
        reset = 1'b0;
        base  = t;
        push(base, 0,     1'b1, 1'b1, 12'h000);
        push(base, 1,     1'b1, 1'b1, 12'hFFF);
        push(base, 320,   1'b1, 1'b1, 12'hFFF);
        push(base, 321,   1'b1, 1'b1, 12'hFF0);
        push(base, 640,   1'b1, 1'b1, 12'hFF0);
        push(base, 641,   1'b1, 1'b1, 12'h0FF);
        push(base, 961,   1'b1, 1'b1, 12'h0F0);
        push(base, 1281,  1'b1, 1'b1, 12'hF0F);
        push(base, 1601,  1'b1, 1'b1, 12'hF00);
        push(base, 1921,  1'b1, 1'b1, 12'h00F);
        push(base, 2240,  1'b1, 1'b1, 12'h00F);
        push(base, 2241,  1'b1, 1'b1, 12'h000);
        push(base, 2560,  1'b1, 1'b1, 12'h000);
        push(base, 2624,  1'b1, 1'b1, 12'h000);
        push(base, 2625,  1'b0, 1'b1, 12'h000);
        push(base, 3008,  1'b0, 1'b1, 12'h000);
        push(base, 3009,  1'b1, 1'b1, 12'h000);
        push(base, 3200,  1'b1, 1'b1, 12'h000);
        push(base, 3201,  1'b1, 1'b1, 12'hFFF);
        push(base, 9761,  1'b1, 1'b1, 12'hFFF);  // v=3 (last visible), h=40
        push(base, 12961, 1'b1, 1'b1, 12'h000);  // v=4 vertical blanking, h=40
        push(base, 16000, 1'b1, 1'b1, 12'h000);
        push(base, 16001, 1'b1, 1'b0, 12'h000);
        push(base, 18625, 1'b0, 1'b0, 12'h000);
        push(base, 22400, 1'b1, 1'b0, 12'h000);
        push(base, 22401, 1'b1, 1'b1, 12'h000);
        push(base, 32000, 1'b1, 1'b1, 12'h000);  // h=799, v=9
        push(base, 32001, 1'b1, 1'b1, 12'hFFF);  // both wrapped to (0,0)
        push(base, 32321, 1'b1, 1'b1, 12'hFF0);
        push(base, 48001, 1'b1, 1'b0, 12'h000);

        wait_until(base + 48200);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending required 0", sb.size());
        end
        total++;
        if (hs_pulses != 17) begin
            bad++;
            $display("FAIL hsync pulse count: got %0d required 17", hs_pulses);
        end
        total++;
        if (vs_falls != 2) begin
            bad++;
            $display("FAIL vsync fall count: got %0d required 2", vs_falls);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
